// File: rtl/led_rotation_monitor_pkg.sv
// Shared types and helpers for the LED rotation monitor.
// FSM state encoding, rotate-left-by-1 and popcount.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + 4'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/led_rotation_monitor_if.sv
// Monitored LED bus, clear control and status outputs of the rotation monitor.
interface led_rotation_monitor_if;
  logic [7:0]  leds_in;
  logic        clr;
  logic        locked;
  logic        step_pulse;
  logic        err_pulse;
  logic [15:0] step_count;
  logic [15:0] err_count;
  logic [31:0] last_period;

  modport master (
    output leds_in, clr,
    input  locked, step_pulse, err_pulse, step_count, err_count, last_period
  );

  modport slave (
    input  leds_in, clr,
    output locked, step_pulse, err_pulse, step_count, err_count, last_period
  );
endinterface

// File: rtl/led_rotation_monitor_sync.sv
// Two-flop synchronizer for a bus that is asynchronous to clk.
module led_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [1:0][WIDTH-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[0], d};
  end

  assign q = ff[1];
endmodule

// File: rtl/led_rotation_monitor.sv
// Checks that the LED pattern rotates left by one at a steady rate;
// locks after an in-window step and flags skips, bad patterns and stalls.
module led_rotation_monitor
  import led_pkg::*;
#(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int STEP_RATE = 4,
  parameter int TOL       = 16,
  parameter int EXP_ONES  = 5
) (
  input logic                  clk,
  input logic                  rst_n,
  led_rotation_monitor_if.slave bus
);
  localparam logic [31:0] P     = 32'(CLK_FREQ / STEP_RATE);
  localparam logic [31:0] WIN_LO = P - 32'(TOL);
  localparam logic [31:0] WIN_HI = P + 32'(TOL);
  localparam logic [3:0]  EXP_W  = 4'(EXP_ONES);

  logic [7:0]  leds_s, prev;
  logic [31:0] cnt, interval, last_period;
  logic [15:0] step_count, err_count;
  logic        change, valid, in_win;
  logic        step_pulse, err_pulse, locked;
  logic        step_nx, err_nx;
  state_t      state, state_nx;

  led_sync #(.WIDTH(8)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.leds_in),
    .q    (leds_s)
  );

  assign change   = (leds_s != prev);
  assign valid    = (leds_s == rotl1(prev));
  // cnt restarts at 0 on the change cycle, so the interval includes that cycle
  assign interval = (cnt == '1) ? cnt : cnt + 32'd1;
  assign in_win   = (interval >= WIN_LO) && (interval <= WIN_HI);

  always_comb begin
    state_nx = state;
    step_nx  = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE:
        if (change && valid && popcount(leds_s) == EXP_W) state_nx = ACQUIRE;
      ACQUIRE:
        if (change) begin
          if (!valid)      state_nx = IDLE;
          else if (in_win) begin
            state_nx = LOCKED;
            step_nx  = 1'b1;
          end
        end
      LOCKED:
        if (change) begin
          if (valid && in_win) step_nx = 1'b1;
          else begin
            err_nx   = 1'b1;
            state_nx = FAULT;
          end
        end else if (cnt == WIN_HI) begin
          err_nx   = 1'b1;
          state_nx = FAULT;
        end
      FAULT:
        if (change && valid) state_nx = ACQUIRE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      prev       <= '0;
      cnt        <= '0;
      last_period <= '0;
      step_pulse <= 1'b0;
      err_pulse  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_nx;
      prev       <= leds_s;
      step_pulse <= step_nx;
      err_pulse  <= err_nx;
      // decoded from next state so locked tracks the state register exactly
      locked     <= (state_nx == LOCKED);
      if (change) begin
        cnt         <= '0;
        last_period <= interval;
      end else if (cnt != '1) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_count <= '0;
      err_count  <= '0;
    end else if (bus.clr) begin
      step_count <= '0;
      err_count  <= '0;
    end else begin
      if (step_pulse && step_count != 16'hFFFF) step_count <= step_count + 16'd1;
      if (err_pulse  && err_count  != 16'hFFFF) err_count  <= err_count  + 16'd1;
    end
  end

  assign bus.locked      = locked;
  assign bus.step_pulse  = step_pulse;
  assign bus.err_pulse   = err_pulse;
  assign bus.step_count  = step_count;
  assign bus.err_count   = err_count;
  assign bus.last_period = last_period;
endmodule

// File: tb/tb_led_rotation_monitor.sv
// Directed bench for led_rotation_monitor at P=10, TOL=1; pulses are
// scoreboarded against an expected-event queue filled as steps are driven.
module tb_led_rotation_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total  = 0;
  logic [7:0] exp_q[$];

  led_rotation_monitor_if bus();

  led_rotation_monitor #(
    .CLK_FREQ (40),
    .STEP_RATE(4),
    .TOL      (1),
    .EXP_ONES (5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // drive a new pattern, then let 'cycles' clock edges pass before the next drive
  task automatic drive(input logic [7:0] pat, input int cycles);
    bus.leds_in = pat;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (bus.step_pulse || bus.err_pulse) begin
      chk("pulse_exclusive", 32'(bus.step_pulse & bus.err_pulse), 32'd0);
      if (exp_q.size() == 0) chk("unexpected_pulse", 32'(bus.step_pulse ? "S" : "E"), 32'd0);
      else chk("pulse_kind", 32'(bus.step_pulse ? "S" : "E"), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    bus.leds_in = 8'h00;
    bus.clr     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked",  32'(bus.locked), 32'd0);
    chk("rst_steps",   32'(bus.step_count), 32'd0);
    chk("rst_errs",    32'(bus.err_count), 32'd0);
    chk("rst_period",  bus.last_period, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // steady rotation of 8'h1F every 10 cycles
    drive(8'h1F, 10);
    drive(8'h3E, 10);
    chk("acq_not_locked", 32'(bus.locked), 32'd0);
    exp_q.push_back("S"); drive(8'h7C, 10);
    chk("lock_after_2nd", 32'(bus.locked), 32'd1);
    chk("period_10", bus.last_period, 32'd10);
    exp_q.push_back("S"); drive(8'hF8, 10);
    exp_q.push_back("S"); drive(8'hF1, 10);
    exp_q.push_back("S"); drive(8'hE3, 10);
    chk("steps_4", 32'(bus.step_count), 32'd4);
    chk("errs_0", 32'(bus.err_count), 32'd0);
    chk("still_locked", 32'(bus.locked), 32'd1);

    // stall: hold pattern well past P+TOL, only one error
    exp_q.push_back("E");
    repeat (25) @(posedge clk);
    #1;
    chk("stall_unlocked", 32'(bus.locked), 32'd0);
    chk("stall_errs_1", 32'(bus.err_count), 32'd1);
    chk("stall_q_empty", 32'(exp_q.size()), 32'd0);
    drive(8'hC7, 10);
    exp_q.push_back("S"); drive(8'h8F, 10);
    chk("relock_stall", 32'(bus.locked), 32'd1);

    bus.clr = 1'b1; @(posedge clk); #1; bus.clr = 1'b0;
    chk("clr_steps", 32'(bus.step_count), 32'd0);
    chk("clr_errs", 32'(bus.err_count), 32'd0);

    // pattern jump 3E -> 55, then recover
    exp_q.push_back("S"); drive(8'h1F, 10);
    exp_q.push_back("S"); drive(8'h3E, 10);
    exp_q.push_back("E"); drive(8'h55, 10);
    chk("jump_errs_1", 32'(bus.err_count), 32'd1);
    chk("jump_unlocked", 32'(bus.locked), 32'd0);
    drive(8'hAA, 10);
    chk("jump_acq", 32'(bus.locked), 32'd0);
    exp_q.push_back("S"); drive(8'h55, 10);
    chk("jump_relock", 32'(bus.locked), 32'd1);

    // early step: interval 8 is below the window
    exp_q.push_back("S"); drive(8'hAA, 8);
    exp_q.push_back("E"); drive(8'h55, 10);
    chk("early_period", bus.last_period, 32'd8);
    chk("early_unlocked", 32'(bus.locked), 32'd0);
    chk("early_errs_2", 32'(bus.err_count), 32'd2);

    // clr coincident with step_pulse
    drive(8'hAA, 10);
    exp_q.push_back("S"); drive(8'h55, 10);
    chk("pre_clr_locked", 32'(bus.locked), 32'd1);
    exp_q.push_back("S");
    bus.leds_in = 8'hAA;
    repeat (3) @(posedge clk);
    #1;
    chk("pulse_at_clr", 32'(bus.step_pulse), 32'd1);
    bus.clr = 1'b1; @(posedge clk); #1; bus.clr = 1'b0;
    chk("clr_wins", 32'(bus.step_count), 32'd0);

    // reset mid-period
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_locked", 32'(bus.locked), 32'd0);
    chk("midrst_steps", 32'(bus.step_count), 32'd0);
    chk("midrst_errs", 32'(bus.err_count), 32'd0);
    chk("midrst_period", bus.last_period, 32'd0);
    chk("midrst_pulses", 32'({bus.step_pulse, bus.err_pulse}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // popcount 4 pattern never leaves IDLE
    drive(8'h0F, 10);
    drive(8'h1E, 10);
    drive(8'h3C, 10);
    drive(8'h78, 10);
    drive(8'hF0, 10);
    chk("pc4_unlocked", 32'(bus.locked), 32'd0);
    chk("pc4_steps", 32'(bus.step_count), 32'd0);
    chk("pc4_errs", 32'(bus.err_count), 32'd0);
    chk("pc4_period", bus.last_period, 32'd10);
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
